// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single external memory command/data port
// between the fc (0), conv (1) and max-pool (2) engines. One owner is
// selected per burst, its command is forwarded, and its write/read beats
// are routed until the last beat, after which ownership rotates.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req_valid,
  input  logic [2:0]            req_we,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*LEN_W-1:0]    req_len,
  output logic [2:0]            req_gnt,
  input  logic [2:0]            wr_valid,
  input  logic [3*DATA_W-1:0]   wr_data,
  output logic [2:0]            wr_ready,
  output logic [2:0]            rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_we,
  output logic [ADDR_W-1:0]     mem_cmd_addr,
  output logic [LEN_W-1:0]      mem_cmd_len,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t             state;
  logic [1:0]         owner;
  logic               cmd_we;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [LEN_W-1:0]   cmd_len;
  logic [LEN_W-1:0]   beat_cnt;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [1:0]         rr_ptr;
`endif

  logic [ADDR_W-1:0]  addr_arr  [3];
  logic [LEN_W-1:0]   len_arr   [3];
  logic [DATA_W-1:0]  wdata_arr [3];
  logic [1:0]         pick;
  logic [2:0]         owner_oh;
  logic               beat;
  logic               last_beat;

  // Unpack the per-engine buses so they can be indexed by engine number.
  for (genvar i = 0; i < 3; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign len_arr[i]   = req_len[i*LEN_W +: LEN_W];
    assign wdata_arr[i] = wr_data[i*DATA_W +: DATA_W];
  end

  // First requester at or after p, searching 0->1->2->0.
  function automatic logic [1:0] pick_rr(input logic [2:0] v, input logic [1:0] p);
    case (p)
      2'd1:    pick_rr = v[1] ? 2'd1 : (v[2] ? 2'd2 : 2'd0);
      2'd2:    pick_rr = v[2] ? 2'd2 : (v[0] ? 2'd0 : 2'd1);
      default: pick_rr = v[0] ? 2'd0 : (v[1] ? 2'd1 : 2'd2);
    endcase
  endfunction

  // Engine index after i, modulo 3.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    next_idx = (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick = pick_rr(req_valid, 2'd0);
`else
  assign pick = pick_rr(req_valid, rr_ptr);
`endif

  assign owner_oh  = 3'b001 << owner;
  assign beat      = ((state == WDATA) && wr_valid[owner] && mem_wready) ||
                     ((state == RDATA) && mem_rvalid);
  assign last_beat = beat && (beat_cnt == cmd_len);

  // Arbitration FSM: latch the winner's command, hand it to memory, then
  // count beats until the burst length is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 2'd0;
      cmd_we   <= 1'b0;
      cmd_addr <= '0;
      cmd_len  <= '0;
      beat_cnt <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr   <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner    <= pick;
            cmd_we   <= req_we[pick];
            cmd_addr <= addr_arr[pick];
            cmd_len  <= len_arr[pick];
            state    <= CMD;
          end
        end
        CMD: begin
          if (mem_cmd_ready) begin
            beat_cnt <= '0;
            state    <= cmd_we ? WDATA : RDATA;
          end
        end
        default: begin
          // Stop counting at len so a full-length burst never wraps.
          if (last_beat) begin
            state  <= IDLE;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr <= next_idx(owner);
`endif
          end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign mem_cmd_valid = (state == CMD);
  assign mem_cmd_we    = cmd_we;
  assign mem_cmd_addr  = cmd_addr;
  assign mem_cmd_len   = cmd_len;
  assign req_gnt       = ((state == CMD) && mem_cmd_ready) ? owner_oh : 3'b000;

  assign mem_wvalid    = (state == WDATA) && wr_valid[owner];
  assign mem_wdata     = (state == WDATA) ? wdata_arr[owner] : '0;
  assign wr_ready      = ((state == WDATA) && mem_wready) ? owner_oh : 3'b000;

  assign rd_valid      = ((state == RDATA) && mem_rvalid) ? owner_oh : 3'b000;
  assign rd_data       = (state == RDATA) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs change on the
// falling clock edge and outputs are sampled 1 ns later.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          req_valid, req_we, req_gnt;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*LEN_W-1:0]  req_len;
  logic [2:0]          wr_valid, wr_ready, rd_valid;
  logic [3*DATA_W-1:0] wr_data;
  logic [DATA_W-1:0]   rd_data, mem_wdata, mem_rdata;
  logic                mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
  logic [ADDR_W-1:0]   mem_cmd_addr;
  logic [LEN_W-1:0]    mem_cmd_len;
  logic                mem_wvalid, mem_wready, mem_rvalid, busy;

  int n_chk  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .req_gnt(req_gnt),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic tog;
    logic [2:0] exp_g;

    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_len = '0;
    wr_valid = '0; wr_data = '0;
    mem_cmd_ready = 1'b0; mem_wready = 1'b1; mem_rvalid = 1'b1;
    mem_rdata = 32'hDEADBEEF;

    // Reset state: all outputs zero, read data gated
    cyc(); #1;
    check("rst_busy", busy, 0);
    check("rst_cmd_valid", mem_cmd_valid, 0);
    check("rst_gnt", req_gnt, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_cmd_addr", mem_cmd_addr, 0);
    mem_rvalid = 1'b0; mem_wready = 1'b0;
    rst = 1'b0;

    // Single read len=3 from conv at 0x100
    req_valid = 3'b010; req_we = 3'b000;
    req_addr[ADDR_W +: ADDR_W] = 27'h100;
    req_len[LEN_W +: LEN_W] = 8'd3;
    #1 check("t1_idle_cmd_valid", mem_cmd_valid, 0);
    cyc(); #1;
    check("t1_cmd_valid", mem_cmd_valid, 1);
    check("t1_cmd_we", mem_cmd_we, 0);
    check("t1_cmd_addr", mem_cmd_addr, 27'h100);
    check("t1_cmd_len", mem_cmd_len, 3);
    check("t1_gnt_wait", req_gnt, 0);
    mem_cmd_ready = 1'b1;
    #1 check("t1_gnt", req_gnt, 3'b010);
    cyc();
    mem_cmd_ready = 1'b0; req_valid = 3'b000;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hA0 + i;
      #1;
      check("t1_rd_valid", rd_valid, 3'b010);
      check("t1_rd_data", rd_data, 32'hA0 + i);
      cyc();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    #1;
    check("t1_busy_end", busy, 0);
    check("t1_stray_rd_valid", rd_valid, 0);
    check("t1_stray_rd_data", rd_data, 0);
    mem_rvalid = 1'b0;

    // Simultaneous requests, len=0, six bursts
    rst = 1'b1; #1 rst = 1'b0;
    req_valid = 3'b111; req_we = 3'b000; req_len = '0;
    mem_cmd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_g = 3'b001;
`else
      exp_g = 3'b001 << (i % 3);
`endif
      cyc(); #1 check("t2_gnt_order", req_gnt, exp_g);
      cyc(); mem_rvalid = 1'b1;
      #1 check("t2_rd_owner", rd_valid, exp_g);
      cyc(); mem_rvalid = 1'b0;
    end
    req_valid = 3'b000; mem_cmd_ready = 1'b0;

    // Write len=7 from fc with mem_wready toggling
    req_valid = 3'b001; req_we = 3'b001;
    req_addr[0 +: ADDR_W] = 27'h2000;
    req_len[0 +: LEN_W] = 8'd7;
    cyc(); #1;
    check("t3_cmd_we", mem_cmd_we, 1);
    check("t3_cmd_len", mem_cmd_len, 7);
    mem_cmd_ready = 1'b1;
    #1 check("t3_gnt", req_gnt, 3'b001);
    cyc();
    mem_cmd_ready = 1'b0; req_valid = 3'b000;
    wr_valid = 3'b111;
    wr_data[DATA_W +: DATA_W] = 32'h1111_1111;
    wr_data[2*DATA_W +: DATA_W] = 32'h2222_2222;
    k = 0; tog = 1'b0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      wr_data[0 +: DATA_W] = 32'hD000_0000 + k;
      mem_wready = tog;
      #1;
      check("t3_wvalid", mem_wvalid, 1);
      check("t3_wr_ready_owner", wr_ready, tog ? 3'b001 : 3'b000);
      if (tog) begin
        check("t3_wdata_order", mem_wdata, 32'hD000_0000 + k);
        k++;
      end
      tog = ~tog;
      cyc();
    end
    check("t3_beats", k, 8);
    mem_wready = 1'b1;
    #1;
    check("t3_busy_end", busy, 0);
    check("t3_wr_ready_end", wr_ready, 0);
    check("t3_wvalid_end", mem_wvalid, 0);
    mem_wready = 1'b0; wr_valid = 3'b000;

    // mem_cmd_ready held low for 5 cycles
    req_valid = 3'b100; req_we = 3'b000;
    req_addr[2*ADDR_W +: ADDR_W] = 27'h3FF0;
    req_len[2*LEN_W +: LEN_W] = 8'd0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_cmd_valid_hold", mem_cmd_valid, 1);
      check("t4_cmd_addr_hold", mem_cmd_addr, 27'h3FF0);
      check("t4_no_gnt", req_gnt, 0);
      cyc();
    end
    mem_cmd_ready = 1'b1;
    #1;
    check("t4_cmd_valid", mem_cmd_valid, 1);
    check("t4_gnt", req_gnt, 3'b100);
    cyc();
    mem_cmd_ready = 1'b0; req_valid = 3'b000; mem_rvalid = 1'b1;
    #1 check("t4_rd_valid", rd_valid, 3'b100);
    cyc(); mem_rvalid = 1'b0;
    #1 check("t4_busy_end", busy, 0);

    // Reset in WDATA after 2 of 4 beats
    req_valid = 3'b001; req_we = 3'b001;
    req_addr[0 +: ADDR_W] = 27'h40;
    req_len[0 +: LEN_W] = 8'd3;
    cyc(); mem_cmd_ready = 1'b1;
    #1 check("t5_gnt", req_gnt, 3'b001);
    cyc();
    mem_cmd_ready = 1'b0; req_valid = 3'b000;
    wr_valid = 3'b001; mem_wready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_data[0 +: DATA_W] = 32'hD1 + i;
      #1 check("t5_wr_ready", wr_ready, 3'b001);
      cyc();
    end
    rst = 1'b1;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_wvalid", mem_wvalid, 0);
    check("t5_rst_wr_ready", wr_ready, 0);
    check("t5_rst_wdata", mem_wdata, 0);
    check("t5_rst_cmd_valid", mem_cmd_valid, 0);
    check("t5_rst_cmd_addr", mem_cmd_addr, 0);
    check("t5_rst_cmd_len", mem_cmd_len, 0);
    check("t5_rst_cmd_we", mem_cmd_we, 0);
    rst = 1'b0; mem_wready = 1'b0; wr_valid = 3'b000;
    req_valid = 3'b100; req_we = 3'b100;
    req_addr[2*ADDR_W +: ADDR_W] = 27'h80;
    req_len[2*LEN_W +: LEN_W] = 8'd3;
    cyc(); #1;
    check("t5_mp_cmd_we", mem_cmd_we, 1);
    check("t5_mp_cmd_addr", mem_cmd_addr, 27'h80);
    mem_cmd_ready = 1'b1;
    #1 check("t5_mp_gnt", req_gnt, 3'b100);
    cyc();
    mem_cmd_ready = 1'b0; req_valid = 3'b000;
    wr_valid = 3'b100; mem_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data[2*DATA_W +: DATA_W] = 32'hE0 + i;
      #1;
      check("t5_mp_busy", busy, 1);
      check("t5_mp_wr_ready", wr_ready, 3'b100);
      check("t5_mp_wdata", mem_wdata, 32'hE0 + i);
      cyc();
    end
    #1 check("t5_mp_busy_end", busy, 0);
    mem_wready = 1'b0; wr_valid = 3'b000;

    // len=255 read: 256 beats without early wrap
    req_valid = 3'b010; req_we = 3'b000;
    req_addr[ADDR_W +: ADDR_W] = 27'h500;
    req_len[LEN_W +: LEN_W] = 8'hFF;
    cyc(); mem_cmd_ready = 1'b1;
    #1;
    check("t6_cmd_len", mem_cmd_len, 8'hFF);
    check("t6_gnt", req_gnt, 3'b010);
    cyc();
    mem_cmd_ready = 1'b0; req_valid = 3'b000; mem_rvalid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem_rdata = i;
      #1 check("t6_rd_beat", rd_valid, 3'b010);
      cyc();
    end
    #1;
    check("t6_busy_end", busy, 0);
    check("t6_rd_valid_end", rd_valid, 0);
    mem_rvalid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory command/data port between the three layer engines: fully-connected (index 0), 2D convolution (index 1) and max pooling (index 2). It sits between the engines' load/store units and the memory controller. Each engine raises a burst request; the arbiter picks one owner, forwards its command, and routes write data and read data for the whole burst. Ownership is then released and passed on by round-robin.

## Interface
- `ADDR_W`, 27: byte address width, matching the engine base-address fields.
- `DATA_W`, 32: data beat width.
- `LEN_W`, 8: burst length field width; beats = len + 1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 3: per-engine burst request, bit i = engine i.
- `req_we` input 3: 1 = write burst, 0 = read burst.
- `req_addr` input 3*ADDR_W: packed start addresses; engine i uses slice [i*ADDR_W +: ADDR_W].
- `req_len` input 3*LEN_W: packed burst lengths.
- `req_gnt` output 3: one-cycle pulse on the cycle engine i's command is accepted by memory.
- `wr_valid` input 3: per-engine write beat valid.
- `wr_data` input 3*DATA_W: packed write data.
- `wr_ready` output 3: write beat accepted.
- `rd_valid` output 3: read beat valid, owner only.
- `rd_data` output DATA_W: read data, shared by all engines and qualified by `rd_valid`.
- `mem_cmd_valid` output 1, `mem_cmd_ready` input 1: memory command handshake.
- `mem_cmd_we` output 1: write flag of the forwarded command.
- `mem_cmd_addr` output ADDR_W: address of the forwarded command.
- `mem_cmd_len` output LEN_W: length of the forwarded command.
- `mem_wvalid` output 1, `mem_wready` input 1, `mem_wdata` output DATA_W: memory write channel.
- `mem_rvalid` input 1, `mem_rdata` input DATA_W: memory read channel; it has no backpressure.
- `busy` output 1: high whenever the arbiter is not in IDLE.

## Operation
- States:
  - IDLE: wait for any `req_valid`.
  - CMD: forward the owner's command to memory.
  - WDATA: stream write beats.
  - RDATA: collect read beats.
- IDLE:
  - If any `req_valid` is set, choose owner = first set bit at or after `rr_ptr`, searching cyclically 0→1→2→0.
  - Register the owner, plus its we/addr/len, into the command register, then go to CMD.
- CMD:
  - `mem_cmd_valid`=1 and the `mem_cmd_*` fields come from the command register.
  - On `mem_cmd_ready`: pulse `req_gnt[owner]`, clear `beat_cnt`, then go to WDATA if we, else RDATA.
- WDATA:
  - `mem_wvalid` = `wr_valid[owner]`; `mem_wdata` = owner slice; `wr_ready[owner]` = `mem_wready`. Other engines' `wr_ready` = 0.
  - On each accepted beat (`mem_wvalid` & `mem_wready`), `beat_cnt` increments.
- RDATA:
  - `rd_valid[owner]` = `mem_rvalid`; `rd_data` = `mem_rdata` (combinational pass-through).
  - On each `mem_rvalid`, `beat_cnt` increments.
- Last beat: an accepted beat with `beat_cnt` == latched len. On the last beat, go to IDLE and set `rr_ptr` = (owner + 1) mod 3.
- `beat_cnt` is LEN_W bits wide, and len = 2^LEN_W−1 is legal, so the counter never has to hold a value above len.
- Engines hold `req_valid`/addr/len stable until `req_gnt`. A `req_valid` dropped while not owner is ignored. The command is latched, so a drop after the owner is chosen does not abort the command.
- `mem_rvalid` outside RDATA is dropped and counted in nothing (a protocol error by the memory controller).
- `rst` asserted at any time, mid-burst included: state goes to IDLE, `rr_ptr`=0, `beat_cnt`=0, and the command register is cleared.

## Timing
- Reset values: all outputs are 0, including `rd_data`, which is gated to 0 outside RDATA.
- Latency: the owner's `req_valid` rises in cycle t with the arbiter idle, and `mem_cmd_valid` rises at t+1.
- Minimum IDLE dwell between bursts is one cycle, so back-to-back bursts from different engines start 1 cycle apart after the last beat.
- A new request arriving during a burst waits; it is not pre-arbitrated.
- Beat transfer is zero-latency in both directions. `wr_ready` and `rd_valid` are combinational from `mem_wready`/`mem_rvalid`.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined:
  - IDLE always picks the lowest set index (fc > cv > mp).
  - `rr_ptr` is not implemented.
- Undefined (default): round-robin as described above.

## Test plan
- Single read, len=3: cv requests addr 0x100. `mem_cmd_*` = {we=0, 0x100, 3} one cycle later, then `req_gnt`=3'b010, 4 `rd_valid[1]` pulses, and back to IDLE (`busy`=0) after the 4th beat.
- Simultaneous requests from all three engines, len=0, repeated ×6: grant order is 0,1,2,0,1,2 (with `MEM_ARB_FIXED_PRIO_EN`: 0,0,... while fc keeps requesting).
- Write len=7 with `mem_wready` toggling every cycle: exactly 8 beats are accepted and `wr_ready` appears only on the owner's bit. Data order matches `wr_data`.
- `mem_cmd_ready` held low 5 cycles: `mem_cmd_valid` stays high, fields stay stable, and no `req_gnt` fires until ready.
- `rst` pulsed in WDATA after 2 of 4 beats: all outputs go to 0 immediately. Next request from mp is granted first with fresh `beat_cnt`.
- len=255 read: exactly 256 beats, counter does not wrap early, return to IDLE.
